// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package seven_seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    // Widest display the nibble helper can address.
    localparam int MAX_DIGITS = 16;

    function automatic logic [6:0] seg_off(input bit common_anode);
        return {7{common_anode}};
    endfunction

    function automatic logic [MAX_DIGITS-1:0] digit_off(input bit common_anode);
        return {MAX_DIGITS{common_anode}};
    endfunction

    function automatic logic [3:0] nibble_sel(input logic [4*MAX_DIGITS-1:0] v,
                                              input logic [3:0]              i);
        return v[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Hex nibble to {g..a} segment pattern, polarity chosen by COMMON_ANODE.
module seven_segment_decoder #(
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    logic [6:0] seg_hi;

    always_comb begin
        seg_hi = 7'h00;
        unique case (nibble)
            4'h0: seg_hi = 7'h3F;
            4'h1: seg_hi = 7'h06;
            4'h2: seg_hi = 7'h5B;
            4'h3: seg_hi = 7'h4F;
            4'h4: seg_hi = 7'h66;
            4'h5: seg_hi = 7'h6D;
            4'h6: seg_hi = 7'h7D;
            4'h7: seg_hi = 7'h07;
            4'h8: seg_hi = 7'h7F;
            4'h9: seg_hi = 7'h6F;
            4'hA: seg_hi = 7'h77;
            4'hB: seg_hi = 7'h7C;
            4'hC: seg_hi = 7'h39;
            4'hD: seg_hi = 7'h5E;
            4'hE: seg_hi = 7'h79;
            4'hF: seg_hi = 7'h71;
        endcase
    end

    assign segments = COMMON_ANODE ? ~seg_hi : seg_hi;

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed display scanner with blank slots and frame-boundary double buffering.
// Optional SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seven_segment_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    output logic                    o_pending,
    output logic                    o_frame_start,
    output logic [6:0]              o_segments,
    output logic [NUM_DIGITS-1:0]   o_digit_en
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_OFF     = seg_off(COMMON_ANODE);
    localparam logic [MAX_DIGITS-1:0] DIG_OFF_ALL = digit_off(COMMON_ANODE);
    localparam logic [NUM_DIGITS-1:0] DIGIT_OFF   = DIG_OFF_ALL[NUM_DIGITS-1:0];

    scan_state_t              state;
    logic [IDX_W-1:0]         idx;
    logic [CNT_W-1:0]         cnt;
    logic [4*NUM_DIGITS-1:0]  disp_reg;
    logic [4*NUM_DIGITS-1:0]  pend_reg;
    logic [4*MAX_DIGITS-1:0]  disp_ext;
    logic [3:0]               cur_nib;
    logic [6:0]               dec_seg;
    logic [NUM_DIGITS-1:0]    digit_hot;
    logic                     frame_evt;
    logic                     show_digit;

    assign disp_ext  = (4*MAX_DIGITS)'(disp_reg);
    assign cur_nib   = nibble_sel(disp_ext, 4'(idx));
    assign digit_hot = NUM_DIGITS'(1) << idx;
    // The start-of-slot cycle of digit 0 is the only point the shown value may change.
    assign frame_evt = i_enable && (state == ST_BLANK) && (idx == '0) && (cnt == '0);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        show_digit = (idx == '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && nibble_sel(disp_ext, 4'(i)) != 4'h0)
                show_digit = 1'b1;
        end
    end
`else
    assign show_digit = 1'b1;
`endif

    seven_segment_decoder #(
        .COMMON_ANODE(COMMON_ANODE)
    ) u_dec (
        .nibble  (cur_nib),
        .segments(dec_seg)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_BLANK;
            idx           <= '0;
            cnt           <= '0;
            disp_reg      <= '0;
            pend_reg      <= '0;
            o_pending     <= 1'b0;
            o_frame_start <= 1'b0;
            o_segments    <= SEG_OFF;
            o_digit_en    <= DIGIT_OFF;
        end else begin
            o_frame_start <= frame_evt;
            if (frame_evt && o_pending)
                disp_reg <= pend_reg;
            // A load on the commit cycle wins the pending flag; the old buffer still commits.
            if (i_load) begin
                pend_reg  <= i_value;
                o_pending <= 1'b1;
            end else if (frame_evt) begin
                o_pending <= 1'b0;
            end

            if (state == ST_DRIVE && show_digit) begin
                o_segments <= dec_seg;
                o_digit_en <= DIGIT_OFF ^ digit_hot;
            end else begin
                o_segments <= SEG_OFF;
                o_digit_en <= DIGIT_OFF;
            end

            if (!i_enable) begin
                state <= ST_BLANK;
                idx   <= '0;
                cnt   <= '0;
            end else begin
                unique case (state)
                    ST_BLANK: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(BLANK_CYCLES - 1))
                            state <= ST_DRIVE;
                    end
                    ST_DRIVE: begin
                        if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                            cnt   <= '0;
                            state <= ST_BLANK;
                            idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Frame-table bench for seven_segment_scan_ctrl (4 digits, 8-cycle slots, 2 blank cycles, common anode).
module tb_seven_segment_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * RD;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    // Active-low {g..a} patterns for 0..F.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        pending, frame_start;
    logic [6:0]  segments;
    logic [3:0]  digit_en;

    always #5 clk = ~clk;

    seven_segment_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .COMMON_ANODE(1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_enable     (enable),
        .i_load       (load),
        .i_value      (value),
        .o_pending    (pending),
        .o_frame_start(frame_start),
        .o_segments   (segments),
        .o_digit_en   (digit_en)
    );

    typedef struct packed {
        logic       fs;
        logic       pend;
        logic [6:0] seg;
        logic [3:0] dig;
    } exp_t;

    typedef struct {
        logic [15:0] disp;
        logic        pend0;
        int          la;
        logic [15:0] va;
        int          lb;
        logic [15:0] vb;
    } frame_t;

    exp_t   sb[$];
    frame_t rows[10];
    int     n_pass = 0;
    int     n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic exp_t slot_exp(input logic [15:0] v, input int d, input int c,
                                      input logic fs, input logic pend);
        exp_t e;
        e.fs   = fs;
        e.pend = pend;
        e.seg  = 7'h7F;
        e.dig  = 4'hF;
        if (c >= BC && !(LZ && d > 0 && (v >> (4 * d)) == 16'h0)) begin
            e.seg = SEG_TAB[v[4*d +: 4]];
            e.dig = 4'hF & ~(4'b0001 << d);
        end
        return e;
    endfunction

    task automatic wait_fs(input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (frame_start) begin
                found = 1'b1;
                break;
            end
        end
        check(name, {31'h0, found}, 32'h1);
    endtask

    // Entered at the negedge of a frame-start cycle; leaves at the negedge of the last cycle.
    task automatic run_frame(input int r, input frame_t f);
        exp_t e;
        for (int k = 0; k < FRAME; k++) begin
            logic p;
            p = f.pend0 | (f.la >= 0 && k > f.la) | (f.lb >= 0 && k > f.lb);
            sb.push_back(slot_exp(f.disp, k / RD, k % RD, k == 0, p));
        end
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0) @(negedge clk);
            e = sb.pop_front();
            check($sformatf("row%0d cyc%0d", r, k),
                  {19'h0, frame_start, pending, segments, digit_en}, {19'h0, e});
            load = 1'b0;
            if (k == f.la) begin load = 1'b1; value = f.va; end
            if (k == f.lb) begin load = 1'b1; value = f.vb; end
        end
    endtask

    initial begin
        frame_t tail;
        rows[0] = '{16'h1234, 1'b0, -1, 16'h0,    -1, 16'h0};
        rows[1] = '{16'h1234, 1'b0, 19, 16'hABCD, -1, 16'h0};
        rows[2] = '{16'hABCD, 1'b0, -1, 16'h0,    -1, 16'h0};
        rows[3] = '{16'hABCD, 1'b0,  9, 16'h1111, 31, 16'h5555};
        rows[4] = '{16'h1111, 1'b1, -1, 16'h0,    -1, 16'h0};
        rows[5] = '{16'h5555, 1'b0,  3, 16'h9876, 12, 16'h0045};
        rows[6] = '{16'h0045, 1'b0,  5, 16'h0000, -1, 16'h0};
        rows[7] = '{16'h0000, 1'b0,  5, 16'hF0E8, -1, 16'h0};
        rows[8] = '{16'hF0E8, 1'b0,  4, 16'h6789, -1, 16'h0};
        rows[9] = '{16'h6789, 1'b0, -1, 16'h0,    -1, 16'h0};
        tail    = '{16'h6789, 1'b0, -1, 16'h0,    -1, 16'h0};

        #2 rst_n = 1'b0;
        #1 check("reset", {19'h0, frame_start, pending, segments, digit_en}, {19'h0, 2'b00, 7'h7F, 4'hF});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load = 1'b1;
        value = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        check("pending after load", {31'h0, pending}, 32'h1);
        check("dark while disabled", {19'h0, frame_start, 1'b0, segments, digit_en}, {19'h0, 2'b00, 7'h7F, 4'hF});
        enable = 1'b1;
        wait_fs(2, "first frame start");

        for (int r = 0; r < 10; r++) begin
            if (r > 0) wait_fs(1, $sformatf("frame period row%0d", r));
            run_frame(r, rows[r]);
        end

        // Enable dropped mid digit-2 drive.
        wait_fs(1, "frame before drop");
        for (int k = 1; k <= 20; k++) @(negedge clk);
        check("digit2 lit before drop", {25'h0, segments, digit_en}, {25'h0, 7'h78, 4'b1011});
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("off after drop", {25'h0, segments, digit_en}, {25'h0, 7'h7F, 4'hF});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("held dark %0d", k), {24'h0, frame_start, segments, digit_en},
                  {24'h0, 1'b0, 7'h7F, 4'hF});
        end
        enable = 1'b1;
        wait_fs(1, "restart frame start");
        run_frame(10, tail);

        // Asynchronous reset while a digit is lit and a value is pending.
        wait_fs(1, "frame before reset");
        load = 1'b1;
        value = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        check("lit before reset", {24'h0, pending, segments, digit_en}, {24'h0, 1'b1, 7'h10, 4'b1110});
        #2 rst_n = 1'b0;
        #1 check("async reset", {19'h0, frame_start, pending, segments, digit_en}, {19'h0, 2'b00, 7'h7F, 4'hF});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
